smm0_strassen_2x2: RTL and testbench

//   Leaf Strassen multiplier. Multiplies two 2x2 matrices of signed DATAWIDTH-bit elements using 7 products.

---
 rtl/smm_pkg.sv | 19 +
 rtl/smm0_pe.sv | 33 +++
 rtl/smm0_strassen_2x2.sv | 192 +++++++++++++++++++
 tb/tb_smm0_strassen_2x2.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smm_pkg.sv
// ---------------------------------------------------------------------------
// smm_pkg
//   Constants shared by the Strassen matrix-multiply blocks.
//   E00..E11     : element index of a 2x2 matrix on a flat bus
//                  (element k sits at [k*DATAWIDTH +: DATAWIDTH])
//   NPROD        : number of Strassen products in one 2x2 step
//   SMM0_LATENCY : clock edges from load sampling to C_out update
// ---------------------------------------------------------------------------
package smm_pkg;

    localparam int E00 = 0;
    localparam int E01 = 1;
    localparam int E10 = 2;
    localparam int E11 = 3;

    localparam int NPROD        = 7;
    localparam int SMM0_LATENCY = 3;

endpackage

// File: rtl/smm0_pe.sv
// ---------------------------------------------------------------------------
// smm0_pe
//   Registered product element: p <= a * b, truncated to DATAWIDTH bits.
//   Truncation makes the result identical for signed and unsigned operands,
//   which gives wrap-around modulo 2^DATAWIDTH.
// Ports
//   clk  in   1          clock, rising edge
//   rst  in   1          synchronous reset, active-high, clears p
//   en   in   1          load a new product; p holds otherwise
//   a    in   DATAWIDTH  multiplicand
//   b    in   DATAWIDTH  multiplier
//   p    out  DATAWIDTH  registered low DATAWIDTH bits of a*b
// ---------------------------------------------------------------------------
module smm0_pe #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] p
);

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= a * b;
        end
    end

endmodule

// File: rtl/smm0_strassen_2x2.sv
// ---------------------------------------------------------------------------
// smm0_strassen_2x2
//   Leaf Strassen multiplier: C = A x B for 2x2 matrices of DATAWIDTH-bit
//   two's-complement elements, using 7 products in a 3-stage pipeline
//   (pre-add -> multiply -> post-add). One load per cycle; sel travels
//   with its data so mixed-mode streams are safe.
//   sel=1 computes A x column 0 of B (only 4 products active; c01=c11=0).
// Configuration
//   SMM0_VALID_OUT_EN : when defined, adds valid_out, high for the one cycle
//                       following each C_out update.
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         synchronous reset, active-high
//   A          in   BUSWIDTH  matrix A, k0=a00 k1=a01 k2=a10 k3=a11
//   B          in   BUSWIDTH  matrix B, same layout
//   load       in   1         A, B, sel valid this cycle
//   sel        in   1         0 = full 2x2 x 2x2, 1 = A x column 0 of B
//   C_out      out  BUSWIDTH  registered product matrix, same layout
//   valid_out  out  1         (SMM0_VALID_OUT_EN only) new result on C_out
// ---------------------------------------------------------------------------
module smm0_strassen_2x2
    import smm_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int BLOCKSIZE = DATAWIDTH,
    parameter int BUSWIDTH  = BLOCKSIZE * 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUSWIDTH-1:0] A,
    input  logic [BUSWIDTH-1:0] B,
    input  logic                load,
    input  logic                sel,
`ifdef SMM0_VALID_OUT_EN
    output logic                valid_out,
`endif
    output logic [BUSWIDTH-1:0] C_out
);

    typedef logic [DATAWIDTH-1:0] elem_t;

    // ---------------- element extraction ----------------
    elem_t a00, a01, a10, a11;
    elem_t b00, b01, b10, b11;
    elem_t b01_eff, b11_eff;

    assign a00 = A[E00*DATAWIDTH +: DATAWIDTH];
    assign a01 = A[E01*DATAWIDTH +: DATAWIDTH];
    assign a10 = A[E10*DATAWIDTH +: DATAWIDTH];
    assign a11 = A[E11*DATAWIDTH +: DATAWIDTH];
    assign b00 = B[E00*DATAWIDTH +: DATAWIDTH];
    assign b01 = B[E01*DATAWIDTH +: DATAWIDTH];
    assign b10 = B[E10*DATAWIDTH +: DATAWIDTH];
    assign b11 = B[E11*DATAWIDTH +: DATAWIDTH];

    // Column-vector mode duplicates column 0 of B into column 1, so the
    // products feeding c00/c10 reduce to a plain matrix x vector.
    assign b01_eff = sel ? b00 : b01;
    assign b11_eff = sel ? b10 : b11;

    // ---------------- stage 1: pre-add ----------------
    elem_t t_next [NPROD];
    elem_t s_next [NPROD];

    always_comb begin
        // NOTE: every element gets a value before the conditional override
        // below, so no path leaves an output unassigned and no latch is inferred.
        t_next[0] = a00 + a11;
        t_next[1] = a10 + a11;
        t_next[2] = a00;
        t_next[3] = a11;
        t_next[4] = a00 + a01;
        t_next[5] = a10 - a00;
        t_next[6] = a01 - a11;

        s_next[0] = b00 + b11_eff;
        s_next[1] = b00;
        s_next[2] = b01_eff - b11_eff;
        s_next[3] = b10 - b00;
        s_next[4] = b11_eff;
        s_next[5] = b00 + b01_eff;
        s_next[6] = b10 + b11_eff;

        // Products 0, 5 and 6 only feed c00/c11 through cancelling terms;
        // in vector mode they are idled at zero.
        if (sel) begin
            t_next[0] = '0;
            t_next[5] = '0;
            t_next[6] = '0;
            s_next[0] = '0;
            s_next[5] = '0;
            s_next[6] = '0;
        end
    end

    elem_t t_q [NPROD];
    elem_t s_q [NPROD];
    logic  v1_q;
    logic  sel1_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: these operand arrays are plain flops, not RAM, so they
            // can and do reset to a known zero state.
            for (int i = 0; i < NPROD; i++) begin
                t_q[i] <= '0;
                s_q[i] <= '0;
            end
            v1_q   <= 1'b0;
            sel1_q <= 1'b0;
        end else begin
            v1_q <= load;
            if (load) begin
                for (int i = 0; i < NPROD; i++) begin
                    t_q[i] <= t_next[i];
                    s_q[i] <= s_next[i];
                end
                sel1_q <= sel;
            end
        end
    end

    // ---------------- stage 2: multiply ----------------
    elem_t m [NPROD];
    logic  v2_q;
    logic  sel2_q;

    for (genvar g = 0; g < NPROD; g++) begin : g_pe
        smm0_pe #(
            .DATAWIDTH (DATAWIDTH)
        ) u_pe (
            .clk (clk),
            .rst (rst),
            .en  (v1_q),
            .a   (t_q[g]),
            .b   (s_q[g]),
            .p   (m[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sel2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sel2_q <= sel1_q;
            end
        end
    end

    // ---------------- stage 3: post-add ----------------
    elem_t c_next [4];

    always_comb begin
        c_next[E00] = '0;
        c_next[E01] = '0;
        c_next[E10] = '0;
        c_next[E11] = '0;
        if (sel2_q) begin
            c_next[E00] = m[2] + m[4];
            c_next[E10] = m[1] + m[3];
        end else begin
            c_next[E00] = m[0] + m[3] - m[4] + m[6];
            c_next[E01] = m[2] + m[4];
            c_next[E10] = m[1] + m[3];
            c_next[E11] = m[0] - m[1] + m[2] + m[5];
        end
    end

`ifdef SMM0_VALID_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= v2_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            C_out <= '0;
        end else if (v2_q) begin
            C_out <= {c_next[E11], c_next[E10], c_next[E01], c_next[E00]};
        end
    end

endmodule

// File: tb/tb_smm0_strassen_2x2.sv
// ---------------------------------------------------------------------------
// tb_smm0_strassen_2x2
//   Self-checking bench for smm0_strassen_2x2. Expected results come from a
//   direct row-by-column 2x2 product computed with 32-bit wrapping arithmetic.
//   Define SMM0_VALID_OUT_EN to also exercise valid_out.
// ---------------------------------------------------------------------------
module tb_smm0_strassen_2x2;
    import smm_pkg::*;

    localparam int DW = 32;
    localparam int BW = DW * 4;

    logic          clk;
    logic          rst;
    logic          load;
    logic          sel;
    logic [BW-1:0] A;
    logic [BW-1:0] B;
    logic [BW-1:0] C_out;
`ifdef SMM0_VALID_OUT_EN
    logic          valid_out;
`endif

    int checks   = 0;
    int failures = 0;

    smm0_strassen_2x2 #(
        .DATAWIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .load      (load),
        .sel       (sel),
`ifdef SMM0_VALID_OUT_EN
        .valid_out (valid_out),
`endif
        .C_out     (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for sampling
    // and inputs set now are taken on the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] pack(input logic [DW-1:0] e00, input logic [DW-1:0] e01,
                                           input logic [DW-1:0] e10, input logic [DW-1:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [BW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: ordinary matrix product, low 32 bits kept.
    function automatic logic [BW-1:0] model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic s);
        logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
        logic [DW-1:0] c00, c01, c10, c11;
        a00 = a[0*DW +: DW]; a01 = a[1*DW +: DW]; a10 = a[2*DW +: DW]; a11 = a[3*DW +: DW];
        b00 = b[0*DW +: DW]; b01 = b[1*DW +: DW]; b10 = b[2*DW +: DW]; b11 = b[3*DW +: DW];
        c00 = a00 * b00 + a01 * b10;
        c10 = a10 * b00 + a11 * b10;
        c01 = a00 * b01 + a01 * b11;
        c11 = a10 * b01 + a11 * b11;
        if (s) begin
            c01 = '0;
            c11 = '0;
        end
        return pack(c00, c01, c10, c11);
    endfunction

    // Issue one load and wait out the pipeline; C_out is then the new result.
    task automatic run_one(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic s);
        A = a; B = b; sel = s; load = 1'b1;
        tick();
        load = 1'b0; A = rnd(); B = rnd(); sel = $urandom_range(0, 1);
        for (int i = 1; i < SMM0_LATENCY; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            A = rnd(); B = rnd();
            tick();
            checks++;
            if (C_out !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h exp=0", i, C_out);
            end
`ifdef SMM0_VALID_OUT_EN
            checks++;
            if (valid_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid cycle=%0d got=%b exp=0", i, valid_out);
            end
`endif
        end
        // The load seen during the last reset cycle must not produce a result.
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < SMM0_LATENCY; i++) begin
            tick();
            checks++;
            if (C_out !== '0) begin
                failures++;
                $display("FAIL reset_release cycle=%0d got=%h exp=0", i, C_out);
            end
        end
    endtask

    task automatic test_basic();
        logic [BW-1:0] exp;
        exp = pack(19, 22, 43, 50);
        A = pack(1, 2, 3, 4); B = pack(5, 6, 7, 8); sel = 1'b0; load = 1'b1;
        tick();  // edge k
        load = 1'b0; A = rnd(); B = rnd();
        tick();  // edge k+1: result not yet visible
        checks++;
        if (C_out !== '0) begin
            failures++;
            $display("FAIL basic_early got=%h exp=0", C_out);
        end
        tick();  // edge k+2
        checks++;
        if (C_out !== exp) begin
            failures++;
            $display("FAIL basic_result got=%h exp=%h", C_out, exp);
        end
`ifdef SMM0_VALID_OUT_EN
        checks++;
        if (valid_out !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid_high got=%b exp=1", valid_out);
        end
`endif
        tick(); tick();
        checks++;
        if (C_out !== exp) begin
            failures++;
            $display("FAIL basic_hold got=%h exp=%h", C_out, exp);
        end
`ifdef SMM0_VALID_OUT_EN
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_low got=%b exp=0", valid_out);
        end
`endif
    endtask

    task automatic test_vector_mode();
        logic [BW-1:0] exp;
        exp = pack(19, 0, 43, 0);
        for (int i = 0; i < 3; i++) begin
            // b01 and b11 are random and must not matter.
            run_one(pack(1, 2, 3, 4), pack(5, $urandom(), 7, $urandom()), 1'b1);
            checks++;
            if (C_out !== exp) begin
                failures++;
                $display("FAIL vector_mode iter=%0d got=%h exp=%h", i, C_out, exp);
            end
        end
    endtask

    task automatic test_signed_wrap();
        logic [BW-1:0] a, exp;
        a = pack(-32'sd1, 32'sd2, 32'sd3, -32'sd4);
        run_one(a, pack(1, 0, 0, 1), 1'b0);
        checks++;
        if (C_out !== a) begin
            failures++;
            $display("FAIL signed_identity got=%h exp=%h", C_out, a);
        end
        exp = pack(32'hFFFF_FFFE, 0, 0, 1);
        run_one(pack(32'h7FFF_FFFF, 0, 0, 1), pack(2, 0, 0, 1), 1'b0);
        checks++;
        if (C_out !== exp) begin
            failures++;
            $display("FAIL wrap_max got=%h exp=%h", C_out, exp);
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] a, b, exp;
        logic          s;
        for (int i = 0; i < 20; i++) begin
            a = rnd(); b = rnd(); s = 1'($urandom_range(0, 1));
            exp = model(a, b, s);
            run_one(a, b, s);
            checks++;
            if (C_out !== exp) begin
                failures++;
                $display("FAIL random iter=%0d sel=%0b got=%h exp=%h", i, s, C_out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] expq[$];
        logic [BW-1:0] exp;
        int            n;
        n = 12;
        for (int i = 0; i < n + SMM0_LATENCY - 1; i++) begin
            if (i < n) begin
                A = rnd(); B = rnd(); sel = (i % 2 == 1); load = 1'b1;
                expq.push_back(model(A, B, sel));
            end else begin
                load = 1'b0; A = rnd(); B = rnd(); sel = ~sel;
            end
            tick();
            if (i >= SMM0_LATENCY - 1) begin
                exp = expq.pop_front();
                checks++;
                if (C_out !== exp) begin
                    failures++;
                    $display("FAIL back_to_back slot=%0d got=%h exp=%h",
                             i - (SMM0_LATENCY - 1), C_out, exp);
                end
`ifdef SMM0_VALID_OUT_EN
                checks++;
                if (valid_out !== 1'b1) begin
                    failures++;
                    $display("FAIL back_to_back_valid slot=%0d got=%b exp=1",
                             i - (SMM0_LATENCY - 1), valid_out);
                end
`endif
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_inflight();
        logic [BW-1:0] exp;
        A = pack(1, 2, 3, 4); B = pack(5, 6, 7, 8); sel = 1'b0; load = 1'b1;
        tick();  // edge k: load taken
        load = 1'b0; rst = 1'b1;
        tick();  // edge k+1: reset
        checks++;
        if (C_out !== '0) begin
            failures++;
            $display("FAIL rst_inflight_clear got=%h exp=0", C_out);
        end
        rst = 1'b0;
        for (int i = 0; i < SMM0_LATENCY; i++) begin
            tick();
            checks++;
            if (C_out !== '0) begin
                failures++;
                $display("FAIL rst_inflight_discard cycle=%0d got=%h exp=0", i, C_out);
            end
        end
        exp = pack(19, 22, 43, 50);
        run_one(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b0);
        checks++;
        if (C_out !== exp) begin
            failures++;
            $display("FAIL rst_recover got=%h exp=%h", C_out, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; sel = 1'b0; A = '0; B = '0;
        test_reset();
        test_basic();
        test_vector_mode();
        test_signed_wrap();
        test_random();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
